// File: rtl/operand_mux_arb_pkg.sv
// Shared constants and helpers for the operand selector: mode encodings and
// the round-robin pointer advance.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Next search start after a grant to channel ptr, wrapping at nch.
   function automatic int rr_next(input int ptr, input int nch);
      return (ptr == nch - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/operand_mux_arb_skid_buf2.sv
// Two-entry valid/ready buffer. The head entry drives the outputs directly and
// in_ready depends only on the registered occupancy.
module skid_buf2 #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   logic [1:0]    count;
   logic [DW-1:0] head_p0;
   logic [DW-1:0] tail_p0;
   logic          push;
   logic          pop;

   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = head_p0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= 2'd0;
         head_p0 <= '0;
         tail_p0 <= '0;
      end else begin
         case (count)
            2'd0: begin
               if (push) begin
                  head_p0 <= in_data;
                  count   <= 2'd1;
               end
            end
            2'd1: begin
               // Simultaneous push/pop replaces the head so order is kept.
               if (push && pop) begin
                  head_p0 <= in_data;
               end else if (push) begin
                  tail_p0 <= in_data;
                  count   <= 2'd2;
               end else if (pop) begin
                  count <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  head_p0 <= tail_p0;
                  count   <= 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/operand_mux_arb.sv
// Registered N-channel operand selector with fixed or round-robin grant,
// feeding a 2-entry skid buffer tagged with the source channel.
module operand_mux_arb
   import mux_pkg::*;
#(
   parameter int WIDTH = 256,
   parameter int NCH   = 2,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SELW-1:0]       rr_ptr;
   logic [SELW-1:0]       gnt_ch;
   logic                  gnt_vld;
   logic [WIDTH-1:0]      gnt_data;
   logic                  space;
   logic                  accept;
   logic [WIDTH+SELW-1:0] buf_out;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = '0;
      if (mode == MODE_FIXED) begin
         if (int'(sel) < NCH) begin
            gnt_vld = 1'b1;
            gnt_ch  = sel;
         end
      end else begin
         // Wrapped segment first; the segment at/after rr_ptr overrides it,
         // and descending order lets the lowest index of each segment win.
         for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i] && (i < int'(rr_ptr))) begin
               gnt_vld = 1'b1;
               gnt_ch  = SELW'(i);
            end
         end
         for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i] && (i >= int'(rr_ptr))) begin
               gnt_vld = 1'b1;
               gnt_ch  = SELW'(i);
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      in_ready = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt_ch == SELW'(i)) begin
            gnt_data    = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = !rst && space && gnt_vld;
         end
      end
   end

   assign accept = |(in_ready & in_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if ((mode == MODE_RR) && accept) begin
         rr_ptr <= SELW'(rr_next(int'(gnt_ch), NCH));
      end
   end

   // Stage boundary: granted operand and its tag enter the skid buffer.
   skid_buf2 #(
      .DW (WIDTH + SELW)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({gnt_data, gnt_ch}),
      .in_valid  (accept),
      .in_ready  (space),
      .out_data  (buf_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_data = buf_out[WIDTH+SELW-1:SELW];
   assign out_ch   = buf_out[SELW-1:0];

endmodule

// File: tb/tb_operand_mux_arb.sv
// Directed and randomized checks of operand_mux_arb against a queue-based
// reference model, on 4-, 2- and 3-channel instances.
module tb_operand_mux_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 4-channel instance
   logic        mode4, out_valid4, out_ready4;
   logic [1:0]  sel4, out_ch4;
   logic [31:0] in_data4;
   logic [3:0]  in_valid4, in_ready4;
   logic [7:0]  out_data4;

   // 2-channel instance
   logic        mode2, out_valid2, out_ready2;
   logic [0:0]  sel2, out_ch2;
   logic [15:0] in_data2;
   logic [1:0]  in_valid2, in_ready2;
   logic [7:0]  out_data2;

   // 3-channel instance
   logic        mode3, out_valid3, out_ready3;
   logic [1:0]  sel3, out_ch3;
   logic [23:0] in_data3;
   logic [2:0]  in_valid3, in_ready3;
   logic [7:0]  out_data3;

   operand_mux_arb #(.WIDTH(8), .NCH(4)) u4 (
      .clk(clk), .rst(rst), .mode(mode4), .sel(sel4), .in_data(in_data4),
      .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
      .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready4));

   operand_mux_arb #(.WIDTH(8), .NCH(2)) u2 (
      .clk(clk), .rst(rst), .mode(mode2), .sel(sel2), .in_data(in_data2),
      .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2),
      .out_ch(out_ch2), .out_valid(out_valid2), .out_ready(out_ready2));

   operand_mux_arb #(.WIDTH(8), .NCH(3)) u3 (
      .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
      .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
      .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3));

   // Reference model of the 4-channel instance: ordered queue of buffered
   // {data, channel} plus the round-robin search start.
   logic [7:0] qd[$];
   logic [1:0] qc[$];
   int         rr_m = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc4(input logic r, input logic m, input logic [1:0] s,
                       input logic [3:0] v, input logic [31:0] d,
                       input logic ordy, output logic acc);
      int         g;
      logic [3:0] er;
      logic       push, pop;
      @(negedge clk);
      rst = r; mode4 = m; sel4 = s; in_valid4 = v; in_data4 = d; out_ready4 = ordy;
      #1;
      g = -1;
      if (m == 1'b0) begin
         g = int'(s);
      end else begin
         for (int k = 0; k < 4; k++)
            if (g < 0 && ((v >> ((rr_m + k) % 4)) & 4'b1) != 4'b0) g = (rr_m + k) % 4;
      end
      er = (r || qd.size() >= 2 || g < 0) ? 4'b0 : (4'b1 << g);
      chk("in_ready", 32'(in_ready4), 32'(er));
      chk("out_valid", 32'(out_valid4), 32'(qd.size() > 0));
      if (qd.size() > 0) begin
         chk("out_data", 32'(out_data4), 32'(qd[0]));
         chk("out_ch", 32'(out_ch4), 32'(qc[0]));
      end
      push = (v & er) != 4'b0;
      pop  = (qd.size() > 0) && ordy;
      acc  = push && !r;
      @(posedge clk);
      if (r) begin
         qd.delete(); qc.delete(); rr_m = 0;
      end else begin
         if (pop) begin
            void'(qd.pop_front()); void'(qc.pop_front());
         end
         if (push) begin
            qd.push_back(8'(d >> (8 * g)));
            qc.push_back(2'(g));
            if (m) rr_m = (g + 1) % 4;
         end
      end
   endtask

   initial begin
      logic acc;
      int   idx;
      rst = 1'b1;
      mode4 = 1'b0; sel4 = '0; in_data4 = '0; in_valid4 = '0; out_ready4 = 1'b0;
      mode2 = 1'b0; sel2 = '0; in_data2 = '0; in_valid2 = '0; out_ready2 = 1'b0;
      mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;
      repeat (2) @(posedge clk);

      // Fill the buffer, then reset twice in the middle of traffic.
      repeat (3) cyc4(1'b0, 1'b0, 2'd1, 4'hF, 32'h44332211, 1'b0, acc);
      repeat (2) cyc4(1'b1, 1'b1, 2'd1, 4'hF, 32'h44332211, 1'b1, acc);

      // Round-robin with all channels valid, data = channel index.
      cyc4(1'b0, 1'b1, 2'd0, 4'hF, 32'h03020100, 1'b1, acc);
      #1;
      chk("first_rr_valid", 32'(out_valid4), 32'd1);
      chk("first_rr_ch", 32'(out_ch4), 32'd0);
      repeat (7) cyc4(1'b0, 1'b1, 2'd0, 4'hF, 32'h03020100, 1'b1, acc);

      // Fixed select of channel 1 on the 2-channel instance.
      #1;
      mode2 = 1'b0; sel2 = 1'b1; in_valid2 = 2'b11; in_data2 = 16'h3CA5; out_ready2 = 1'b1;
      repeat (5) begin
         cyc4(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, acc);
         #1;
         chk("fix2_in_ready", 32'(in_ready2), 32'h2);
         chk("fix2_out_valid", 32'(out_valid2), 32'd1);
         chk("fix2_out_data", 32'(out_data2), 32'h3C);
         chk("fix2_out_ch", 32'(out_ch2), 32'd1);
      end
      in_valid2 = 2'b00;

      // Out-of-range select on the 3-channel instance.
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'hCCBBAA; out_ready3 = 1'b1;
      repeat (4) begin
         cyc4(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, acc);
         #1;
         chk("sel3_in_ready", 32'(in_ready3), 32'd0);
         chk("sel3_out_valid", 32'(out_valid3), 32'd0);
      end
      in_valid3 = 3'b000;

      // Back-pressure: channel 0 streams 1..4, out_ready low for 3 cycles.
      repeat (3) cyc4(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, acc);
      idx = 0;
      for (int t = 0; t < 10; t++) begin
         cyc4(1'b0, 1'b0, 2'd0, (idx < 4) ? 4'h1 : 4'h0, 32'(idx + 1), (t >= 3), acc);
         if (t == 2) chk("bp_full_ready", 32'(in_ready4), 32'd0);
         if (acc) idx++;
      end
      chk("bp_all_sent", 32'(idx), 32'd4);

      // Sparse round-robin: channel 2 alone, then channel 1 alone.
      cyc4(1'b0, 1'b1, 2'd0, 4'b0100, 32'h00CC0000, 1'b1, acc);
      #1;
      chk("sparse_ch2", 32'(out_ch4), 32'd2);
      chk("sparse_ptr", 32'(rr_m), 32'd3);
      cyc4(1'b0, 1'b1, 2'd0, 4'b0010, 32'h0000BB00, 1'b1, acc);
      #1;
      chk("sparse_wrap_ch1", 32'(out_ch4), 32'd1);
      chk("sparse_wrap_data", 32'(out_data4), 32'hBB);

      // Randomized traffic against the model.
      for (int t = 0; t < 400; t++) begin
         cyc4(($urandom_range(0, 59) == 0), 1'($urandom), 2'($urandom),
              4'($urandom), $urandom(), ($urandom_range(0, 3) != 0), acc);
      end
      cyc4(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b1, acc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
